cache_wb_buffer: RTL and testbench
==================================

Name: cache_wb_buffer

Overview:
Write-back buffer between the data cache and the memory bus. It accepts dirty lines evicted by the cache-side writer, stores them in a small in-order queue, and drains each line to memory as one address phase, a fixed-length data burst and a write response. A combinational lookup port lets the miss path detect reads to lines that have not yet drained.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits
BEAT_WIDTH, 64, memory data beat width; BEATS = LINE_WIDTH/BEAT_WIDTH (integer, >=2)
DEPTH, 2, number of buffered lines (power of 2, >=2)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
evict_valid  in  1  eviction request from cache
evict_ready  out  1  buffer can accept a line
evict_addr  in  ADDR_WIDTH  line address; offset bits ignored
evict_data  in  LINE_WIDTH  line data
mem_aw_valid  out  1  write address valid
mem_aw_ready  in  1  write address accepted
mem_aw_addr  out  ADDR_WIDTH  line-aligned address; offset bits forced to 0
mem_w_valid  out  1  write beat valid
mem_w_ready  in  1  write beat accepted
mem_w_data  out  BEAT_WIDTH  current beat
mem_w_last  out  1  final beat of burst
mem_b_valid  in  1  write response valid
mem_b_ready  out  1  buffer ready for response
lookup_addr  in  ADDR_WIDTH  miss-path probe address
lookup_hit  out  1  probe line matches a buffered entry
empty  out  1  no entries buffered

Behaviour:
- Reset is rstn, synchronous, active-low, on clk. Reset clears count, head/tail pointers, beat counter and all entry valid bits, and forces state IDLE. After reset: evict_ready=1, empty=1, and mem_aw_valid, mem_w_valid, mem_w_last, mem_b_ready and lookup_hit are all 0.
- Reset asserted mid-burst abandons the transaction and discards all entries. There is no recovery handshake.
- Enqueue: fires on evict_valid && evict_ready; the entry is written at tail, tail increments mod DEPTH, count increments.
- evict_ready = (count != DEPTH), taken from registered count. There is no full-bypass: a pop in the same cycle does not raise evict_ready.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Line offset width is OFS = log2(LINE_WIDTH/8).
- Drain FSM, strictly in order, head entry only:
  - IDLE: if count != 0, go to ADDR at the next edge.
  - ADDR: mem_aw_valid=1, mem_aw_addr = head address with OFS low bits zero. On mem_aw_ready, go to DATA with beat=0.
  - DATA: mem_w_valid=1, mem_w_data = head line bits [beat*BEAT_WIDTH +: BEAT_WIDTH] (beat 0 is the least significant), mem_w_last = (beat == BEATS-1). On mem_w_ready, beat increments; on the last-beat handshake, go to RESP.
  - RESP: mem_b_ready=1. On mem_b_valid, pop the head (clear its valid bit, head+1 mod DEPTH, count-1) and go to IDLE.
- Valid and data signals are held stable while waiting for ready. Ready stalls of any length are tolerated.
- The head entry is not removed until its response arrives.
- lookup_hit is combinational: OR over valid entries of (entry addr[ADDR_WIDTH-1:OFS] == lookup_addr[ADDR_WIDTH-1:OFS]). It includes the head entry during ADDR/DATA/RESP and deasserts in the cycle after the pop.
- A line enqueued in the same cycle is not visible to lookup until the next cycle.
- Duplicate addresses may coexist in the queue and drain in arrival order.
- empty = (count == 0), registered.
- Latency with all readies high: enqueue handshake in cycle 0, aw_valid in cycle 2, W beats in cycles 3..2+BEATS, b_ready in cycle 3+BEATS.

Test Plan:
- Reset, then idle with all inputs 0 -> evict_ready=1, empty=1, and all mem_* valid/ready outputs are 0 for 10 cycles.
- Single eviction: addr 0x0000_1234, data with beat k = 0x1111_1111_1111_1111*(k+1), all readies high, b_valid high -> aw_valid in cycle 2 with addr 0x0000_1220; beats 0x11..,0x22..,0x33..,0x44.. in cycles 3-6 with last in cycle 6; pop in cycle 7; empty=1 in cycle 8.
- Back-pressure: mem_w_ready low for 3 cycles on beat 1 -> mem_w_data stays at beat 1 and mem_w_valid stays 1; the burst completes with exactly 4 handshakes.
- Full: enqueue 2 lines with aw_ready=0 -> evict_ready=0. A third evict_valid is held and accepted only in the cycle after the first pop; drain order is A, B, C.
- Lookup: buffer line 0x0000_2000, probe 0x0000_201C -> hit=1; probe 0x0000_2020 -> hit=0; after b handshake, hit=0 on the next cycle.
- Reset asserted during DATA beat 2 -> next cycle: state IDLE, count 0, w_valid=0, evict_ready=1, lookup_hit=0.

Source files
------------

// File: rtl/cache_wb_buffer.sv
// Write-back buffer: queues evicted dirty lines and drains them in order as
// one address phase, a fixed-length beat burst and a write response.
`timescale 1ns/1ps
module cache_wb_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  evict_valid,
  output logic                  evict_ready,
  input  logic [ADDR_WIDTH-1:0] evict_addr,
  input  logic [LINE_WIDTH-1:0] evict_data,
  output logic                  mem_aw_valid,
  input  logic                  mem_aw_ready,
  output logic [ADDR_WIDTH-1:0] mem_aw_addr,
  output logic                  mem_w_valid,
  input  logic                  mem_w_ready,
  output logic [BEAT_WIDTH-1:0] mem_w_data,
  output logic                  mem_w_last,
  input  logic                  mem_b_valid,
  output logic                  mem_b_ready,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic                  empty
);

  localparam int unsigned BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int unsigned OFS   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned BW    = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [PW-1:0]                   head;
  logic [PW-1:0]                   tail;
  logic [CW-1:0]                   count;
  logic [BW-1:0]                   beat;
  logic [DEPTH-1:0]                vld;
  logic [ADDR_WIDTH-1:0]           addr_mem [DEPTH];
  logic [BEATS-1:0][BEAT_WIDTH-1:0] data_mem [DEPTH];

  logic push;
  logic pop;
  logic aw_fire;
  logic w_fire;
  logic last_beat;
  logic unused_ofs;

  assign push      = evict_valid && evict_ready;
  assign pop       = (state == RESP) && mem_b_valid;
  assign aw_fire   = (state == ADDR) && mem_aw_ready;
  assign w_fire    = (state == DATA) && mem_w_ready;
  assign last_beat = (beat == BW'(BEATS - 1));

  // Offset bits never take part in matching or addressing.
  assign unused_ofs = ^{evict_addr[OFS-1:0], lookup_addr[OFS-1:0]};

  assign evict_ready = (count != CW'(DEPTH));
  assign empty       = (count == '0);
  assign mem_aw_addr = {addr_mem[head][ADDR_WIDTH-1:OFS], OFS'(0)};
  assign mem_w_data  = data_mem[head][beat];

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = ADDR;
      ADDR:    if (mem_aw_ready) state_nxt = DATA;
      DATA:    if (mem_w_ready && last_beat) state_nxt = RESP;
      RESP:    if (mem_b_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_aw_valid = 1'b0;
    mem_w_valid  = 1'b0;
    mem_w_last   = 1'b0;
    mem_b_ready  = 1'b0;
    case (state)
      ADDR:    mem_aw_valid = 1'b1;
      DATA: begin
        mem_w_valid = 1'b1;
        mem_w_last  = last_beat;
      end
      RESP:    mem_b_ready = 1'b1;
      default: ;
    endcase
  end

  // Queue pointers, occupancy and beat counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      beat  <= '0;
      vld   <= '0;
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (aw_fire)     beat <= '0;
      else if (w_fire) beat <= beat + BW'(1);
    end
  end

  // Entry storage; contents are only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= evict_addr;
      data_mem[tail] <= evict_data;
    end
  end

  // Miss-path probe against every buffered line, head included
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (addr_mem[i][ADDR_WIDTH-1:OFS] == lookup_addr[ADDR_WIDTH-1:OFS]))
        lookup_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Directed self-checking bench for cache_wb_buffer with hand-computed expectations.
`timescale 1ns/1ps
module tb_cache_wb_buffer;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned LINE_WIDTH = 256;
  localparam int unsigned BEAT_WIDTH = 64;
  localparam int unsigned DEPTH      = 2;

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  evict_valid;
  logic                  evict_ready;
  logic [ADDR_WIDTH-1:0] evict_addr;
  logic [LINE_WIDTH-1:0] evict_data;
  logic                  mem_aw_valid;
  logic                  mem_aw_ready;
  logic [ADDR_WIDTH-1:0] mem_aw_addr;
  logic                  mem_w_valid;
  logic                  mem_w_ready;
  logic [BEAT_WIDTH-1:0] mem_w_data;
  logic                  mem_w_last;
  logic                  mem_b_valid;
  logic                  mem_b_ready;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  lookup_hit;
  logic                  empty;

  int n_chk  = 0;
  int n_fail = 0;
  int w_hs   = 0;
  logic [ADDR_WIDTH-1:0] aw_log[$];
  logic [LINE_WIDTH-1:0] line_a;

  cache_wb_buffer #(
    .ADDR_WIDTH(ADDR_WIDTH), .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready), .mem_aw_addr(mem_aw_addr),
    .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_data(mem_w_data),
    .mem_w_last(mem_w_last),
    .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .empty(empty)
  );

  always #5 clk = ~clk;

  // Bus-side monitors: W handshake count and AW issue order
  always @(posedge clk) begin
    if (rstn && mem_w_valid && mem_w_ready) w_hs <= w_hs + 1;
    if (rstn && mem_aw_valid && mem_aw_ready) aw_log.push_back(mem_aw_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_b(input int max);
    int n = 0;
    while (!mem_b_ready && n < max) begin
      tick;
      n++;
    end
    chk("wait_b_ready", 256'(mem_b_ready), 256'(1));
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (!(empty && !mem_aw_valid) && n < max) begin
      tick;
      n++;
    end
    chk("wait_empty", 256'(empty), 256'(1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_a       = {B3, B2, B1, B0};
    rstn         = 1'b0;
    evict_valid  = 1'b0;
    evict_addr   = '0;
    evict_data   = '0;
    mem_aw_ready = 1'b0;
    mem_w_ready  = 1'b0;
    mem_b_valid  = 1'b0;
    lookup_addr  = '0;
    tick;
    tick;
    rstn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      chk("idle_evict_ready", 256'(evict_ready), 256'(1));
      chk("idle_empty", 256'(empty), 256'(1));
      chk("idle_bus", 256'({mem_aw_valid, mem_w_valid, mem_w_last, mem_b_ready, lookup_hit}), 256'(0));
      tick;
    end

    // Single eviction with all readies high
    mem_aw_ready = 1'b1; mem_w_ready = 1'b1; mem_b_valid = 1'b1;
    evict_valid = 1'b1; evict_addr = 32'h0000_1234; evict_data = line_a;
    chk("single_c0_ready", 256'(evict_ready), 256'(1));
    tick;
    evict_valid = 1'b0;
    chk("single_c1_aw", 256'(mem_aw_valid), 256'(0));
    chk("single_c1_empty", 256'(empty), 256'(0));
    tick;
    chk("single_c2_aw", 256'(mem_aw_valid), 256'(1));
    chk("single_c2_addr", 256'(mem_aw_addr), 256'(32'h0000_1220));
    tick;
    chk("single_c3_data", 256'({mem_w_valid, mem_w_last, mem_w_data}), 256'({1'b1, 1'b0, B0}));
    tick;
    chk("single_c4_data", 256'({mem_w_valid, mem_w_last, mem_w_data}), 256'({1'b1, 1'b0, B1}));
    tick;
    chk("single_c5_data", 256'({mem_w_valid, mem_w_last, mem_w_data}), 256'({1'b1, 1'b0, B2}));
    tick;
    chk("single_c6_data", 256'({mem_w_valid, mem_w_last, mem_w_data}), 256'({1'b1, 1'b1, B3}));
    tick;
    chk("single_c7_bready", 256'({mem_b_ready, mem_w_valid}), 256'(2'b10));
    chk("single_c7_empty", 256'(empty), 256'(0));
    tick;
    chk("single_c8_empty", 256'(empty), 256'(1));
    chk("single_c8_bready", 256'(mem_b_ready), 256'(0));

    // W back-pressure on beat 1
    w_hs = 0;
    evict_valid = 1'b1; evict_addr = 32'h0000_3040; evict_data = line_a;
    tick;
    evict_valid = 1'b0;
    tick;
    tick;
    chk("bp_beat0", 256'(mem_w_data), 256'(B0));
    tick;
    mem_w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 256'(mem_w_valid), 256'(1));
      chk("bp_hold_data", 256'(mem_w_data), 256'(B1));
      tick;
    end
    mem_w_ready = 1'b1;
    chk("bp_release_data", 256'(mem_w_data), 256'(B1));
    wait_b(10);
    chk("bp_handshakes", 256'(w_hs), 256'(4));
    tick;
    chk("bp_empty", 256'(empty), 256'(1));

    // Full queue, held third eviction, in-order drain
    mem_aw_ready = 1'b0; mem_w_ready = 1'b0; mem_b_valid = 1'b0;
    aw_log.delete();
    evict_valid = 1'b1; evict_addr = 32'h0000_0100; evict_data = line_a;
    tick;
    evict_addr = 32'h0000_0200;
    chk("full_c1_ready", 256'(evict_ready), 256'(1));
    tick;
    evict_addr = 32'h0000_0300;
    chk("full_c2_ready", 256'(evict_ready), 256'(0));
    chk("full_c2_aw", 256'(mem_aw_valid), 256'(1));
    tick;
    chk("full_c3_ready", 256'(evict_ready), 256'(0));
    mem_aw_ready = 1'b1; mem_w_ready = 1'b1; mem_b_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    chk("full_pop_bready", 256'(mem_b_ready), 256'(1));
    chk("full_pop_no_bypass", 256'(evict_ready), 256'(0));
    tick;
    chk("full_after_pop_ready", 256'(evict_ready), 256'(1));
    tick;
    evict_valid = 1'b0;
    chk("full_refilled", 256'(evict_ready), 256'(0));
    wait_empty(60);
    chk("full_order_n", 256'(aw_log.size()), 256'(3));
    if (aw_log.size() == 3) begin
      chk("full_order_a", 256'(aw_log[0]), 256'(32'h0000_0100));
      chk("full_order_b", 256'(aw_log[1]), 256'(32'h0000_0200));
      chk("full_order_c", 256'(aw_log[2]), 256'(32'h0000_0300));
    end

    // Lookup probe
    mem_aw_ready = 1'b0; mem_w_ready = 1'b0; mem_b_valid = 1'b0;
    evict_valid = 1'b1; evict_addr = 32'h0000_2000; evict_data = line_a;
    lookup_addr = 32'h0000_2000;
    #1;
    chk("lk_same_cycle", 256'(lookup_hit), 256'(0));
    tick;
    evict_valid = 1'b0;
    lookup_addr = 32'h0000_201C;
    #1;
    chk("lk_hit", 256'(lookup_hit), 256'(1));
    lookup_addr = 32'h0000_2020;
    #1;
    chk("lk_next_line", 256'(lookup_hit), 256'(0));
    lookup_addr = 32'h0000_201C;
    mem_aw_ready = 1'b1; mem_w_ready = 1'b1; mem_b_valid = 1'b1;
    wait_b(20);
    #1;
    chk("lk_resp_hit", 256'(lookup_hit), 256'(1));
    tick;
    chk("lk_after_pop", 256'(lookup_hit), 256'(0));

    // Reset during DATA beat 2 with a second line queued
    evict_valid = 1'b1; evict_addr = 32'h0000_4000; evict_data = line_a;
    tick;
    evict_addr = 32'h0000_5000;
    tick;
    evict_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("rst_pre_beat2", 256'(mem_w_data), 256'(B2));
    lookup_addr = 32'h0000_5000;
    rstn = 1'b0;
    tick;
    chk("rst_w_valid", 256'(mem_w_valid), 256'(0));
    chk("rst_evict_ready", 256'(evict_ready), 256'(1));
    chk("rst_empty", 256'(empty), 256'(1));
    chk("rst_lookup", 256'(lookup_hit), 256'(0));
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_stays_idle", 256'({mem_aw_valid, mem_w_valid, mem_b_ready}), 256'(0));
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
